// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEF  = 14;
    localparam int DIGITS_DEF = 4;
    localparam int DIGIT_W    = 4;

    // Largest value representable with the given number of BCD digits (10^digits - 1)
    function automatic longint unsigned bcd_max_of(input int digits);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam longint unsigned BCD_MAX = bcd_max_of(DIGITS_DEF);

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Correct the digit before the next left shift so it carries properly into decimal
    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) with
// saturation to all nines, leading-zero blanking mask and a valid/ready result handshake.
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          value,
    input  logic                      value_valid,
    output logic                      value_ready,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      overflow,
    output logic [DIGITS-1:0]         blank_mask,
    output logic                      bcd_valid,
    input  logic                      bcd_ready
);

    localparam int              ACC_W = DIGIT_W * DIGITS;
    localparam int              CNT_W = $clog2(WIDTH + 1);
    localparam longint unsigned MAX_L = bcd_max_of(DIGITS);
    // Only used when the input exceeds MAX_L, which implies MAX_L fits in WIDTH bits
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_L);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic               valid_q, valid_d;

    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shift;
    logic [DIGITS-1:0]  blank_next;
    logic               zero_run;
    logic               value_gt;

    // One add-3 corrector per accumulator digit
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_add3 u_add3 (
                .digit_i (acc_q[gi*DIGIT_W +: DIGIT_W]),
                .digit_o (acc_adj[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Corrected digits shifted left, next binary MSB entering digit 0
    assign acc_shift = {acc_adj[ACC_W-2:0], shift_q[WIDTH-1]};

    assign value_gt = (64'(value) > MAX_L);

    // Leading-zero mask of the freshly shifted accumulator; digit 0 is never blanked
    always_comb begin
        blank_next = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (acc_shift[i*DIGIT_W +: DIGIT_W] == 4'd0);
            blank_next[i] = zero_run;
        end
    end

    // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        blank_d    = blank_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                if (value_valid) begin
                    shift_d    = value_gt ? MAX_W : value;
                    acc_d      = '0;
                    ovf_pend_d = value_gt;
                    cnt_d      = CNT_W'(WIDTH);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = shift_q << 1;
                acc_d   = acc_shift;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    // Last iteration: publish the result on the same edge
                    state_d = DONE;
                    bcd_d   = acc_shift;
                    ovf_d   = ovf_pend_q;
                    blank_d = blank_next;
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bcd_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            blank_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            blank_q    <= blank_d;
            valid_q    <= valid_d;
        end
    end

    assign value_ready = (state_q == IDLE);
    assign bcd         = bcd_q;
    assign overflow    = ovf_q;
    assign blank_mask  = blank_q;
    assign bcd_valid   = valid_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Self-checking bench for bcd_converter: directed corner cases plus random values
// compared against an arithmetic decimal model.
module tb_bcd_converter;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] value;
    logic        value_valid;
    logic        value_ready;
    logic [15:0] bcd;
    logic        overflow;
    logic [3:0]  blank_mask;
    logic        bcd_valid;
    logic        bcd_ready;

    int n_cmp = 0;
    int n_err = 0;

    bcd_converter #(.WIDTH(14), .DIGITS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .bcd         (bcd),
        .overflow    (overflow),
        .blank_mask  (blank_mask),
        .bcd_valid   (bcd_valid),
        .bcd_ready   (bcd_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: saturate to 9999, split into decimal digits arithmetically
    function automatic logic [15:0] model_bcd(input int v);
        int m;
        logic [15:0] r;
        m = (v > 9999) ? 9999 : v;
        r = 16'h0;
        r[3:0]   = 4'(m % 10);
        r[7:4]   = 4'((m / 10) % 10);
        r[11:8]  = 4'((m / 100) % 10);
        r[15:12] = 4'((m / 1000) % 10);
        return r;
    endfunction

    // Digit i and everything above it is zero exactly when the value is below 10^i
    function automatic logic [3:0] model_blank(input int v);
        int m;
        logic [3:0] b;
        m = (v > 9999) ? 9999 : v;
        b = 4'b0000;
        b[1] = (m < 10);
        b[2] = (m < 100);
        b[3] = (m < 1000);
        return b;
    endfunction

    // Full conversion: accept, measure latency, hold off bcd_ready for 'hold' cycles, release.
    // With 'glitch' set, value_valid is pulsed with value=42 in the middle of SHIFT.
    task automatic convert(input int v, input int hold, input bit glitch);
        int n;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_blank;
        exp_bcd   = model_bcd(v);
        exp_blank = model_blank(v);
        check("ready_before_accept", 32'(value_ready), 32'd1);
        value       = 14'(v);
        value_valid = 1'b1;
        @(posedge clk);
        #1;
        value_valid = 1'b0;
        check("ready_in_shift", 32'(value_ready), 32'd0);
        n = 0;
        while (!bcd_valid && n < 40) begin
            if (glitch && n == 3) begin
                value       = 14'd42;
                value_valid = 1'b1;
            end
            if (glitch && n == 6) value_valid = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        value_valid = 1'b0;
        check("latency", 32'(n), 32'd14);
        check("bcd", 32'(bcd), 32'(exp_bcd));
        check("overflow", 32'(overflow), (v > 9999) ? 32'd1 : 32'd0);
        check("blank_mask", 32'(blank_mask), 32'(exp_blank));
        check("ready_in_done", 32'(value_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(bcd_valid), 32'd1);
            check("hold_bcd", 32'(bcd), 32'(exp_bcd));
        end
        bcd_ready = 1'b1;
        @(posedge clk);
        #1;
        bcd_ready = 1'b0;
        check("valid_cleared", 32'(bcd_valid), 32'd0);
        check("ready_after_done", 32'(value_ready), 32'd1);
        check("bcd_held_in_idle", 32'(bcd), 32'(exp_bcd));
        $display("conv value=%0d bcd=%h overflow=%b blank=%b latency=%0d hold=%0d",
                 v, bcd, overflow, blank_mask, n, hold);
    endtask

    initial begin
        int rv;
        reset       = 1'b1;
        value       = '0;
        value_valid = 1'b0;
        bcd_ready   = 1'b0;
        @(posedge clk);
        #1;
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_blank", 32'(blank_mask), 32'd0);
        check("rst_valid", 32'(bcd_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(value_ready), 32'd1);

        // Directed corner cases
        convert(0, 0, 1'b0);
        convert(1234, 0, 1'b0);
        convert(7, 1, 1'b0);
        convert(9999, 0, 1'b0);
        convert(10000, 2, 1'b0);
        convert(16383, 0, 1'b0);
        convert(1234, 5, 1'b0);
        convert(5678, 0, 1'b1);

        // Reset in the middle of a 4321 conversion (previous result 0x5678 is still shown)
        check("ready_before_abort", 32'(value_ready), 32'd1);
        value       = 14'd4321;
        value_valid = 1'b1;
        @(posedge clk);
        #1;
        value_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        check("abort_blank", 32'(blank_mask), 32'd0);
        check("abort_valid", 32'(bcd_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("ready_after_abort", 32'(value_ready), 32'd1);
        @(posedge clk);
        #1;
        check("no_partial_valid", 32'(bcd_valid), 32'd0);
        convert(4321, 0, 1'b0);

        // Random values over the full input range, with random back-pressure
        for (int t = 0; t < 24; t++) begin
            if (t % 4 == 0) rv = 9990 + int'($urandom_range(0, 20));
            else            rv = int'($urandom_range(0, 16383));
            convert(rv, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
